seq_gen_stream: RTL and testbench
=================================

// Module: seq_gen_stream
// PURPOSE
//  Parametrised integer-recurrence sequence generator with a valid/ready output stream.
//  Modes: Fibonacci, Lucas, Tribonacci, and custom two-seed.
//  Emits n_terms terms per start command and ends early, flagged, before any term exceeds WIDTH bits.
//  Acts as a datapath test source and a demo peripheral behind the board I/O wrappers.
// PARAMETERS
//  WIDTH  16  term width in bits (>=4)
//  CNT_W  8   width of n_terms and out_idx
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, synchronous, active-high
//  start      in   1      begin a sequence; sampled only in IDLE
//  mode       in   2      00 Fib(0,1), 01 Lucas(2,1), 10 Trib(0,0,1), 11 custom(seed0,seed1)
//  seed0      in   WIDTH  custom term 0 (mode 11 only)
//  seed1      in   WIDTH  custom term 1 (mode 11 only)
//  n_terms    in   CNT_W  number of terms requested
//  out_ready  in   1      consumer accepts out_data
//  out_valid  out  1      out_data/out_idx hold a term
//  out_data   out  WIDTH  current term
//  out_idx    out  CNT_W  index of current term, starting at 0
//  busy       out  1      sequence in progress (RUN or DONE)
//  done       out  1      one-cycle pulse: sequence finished
//  ovf        out  1      sticky: last sequence stopped on overflow
// BEHAVIOUR
//  Reset values: out_valid=0, out_data=0, out_idx=0, busy=0, done=0, ovf=0, state=IDLE.
//   rst at any time, including mid-sequence, aborts the sequence with no done pulse.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: start=1 latches mode, seeds and n_terms, and clears ovf.
//     If n_terms=0, go to DONE (no term emitted). Otherwise go to RUN.
//     Term 0 is presented with out_valid=1 and out_idx=0 on the cycle after start (latency 1).
//   RUN: busy=1, out_valid=1. A transfer is out_valid & out_ready at a rising edge.
//     While stalled (valid & !ready), out_data and out_idx hold stable.
//     On a transfer, the next term and out_idx+1 are presented the following cycle, with no bubble.
//     Back-to-back transfers give 1 term per clock.
//   RUN exits on transfer of out_idx=n_terms-1, or on a transfer whose successor term
//     exceeds 2^WIDTH-1 (ovf<=1). Either exit goes to DONE and drops out_valid the next cycle.
//   DONE: one cycle; done=1, busy=1, out_valid=0; then IDLE.
//  start is ignored outside IDLE; no queuing.
//  mode, seeds and n_terms changing during RUN has no effect.
//  Recurrence, where term k is t(k):
//   Two-term modes: t(k+2)=t(k)+t(k+1).
//   Tribonacci: t(k+3)=t(k)+t(k+1)+t(k+2).
//   Sums are computed at WIDTH+2 bits. A term that does not fit in WIDTH bits is never emitted; it never wraps.
//   Any seed is itself a valid term and is always emitted if requested.
//  The overflow check applies to every term, including terms already precomputed in the pipeline.
//   Each internal term register carries a "too big" tag.
//   The tag propagates: a sum with any tagged operand is itself tagged.
//  If n_terms is reached and overflow occur on the same transfer, this counts as a normal finish: ovf=0.
//  ovf holds until the next accepted start or rst.
//  out_data holds its last value in IDLE/DONE.
//  out_idx resets to 0 on an accepted start.
// TESTING
//  1 mode=00, n=10, ready=1: 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles, idx 0..9.
//    done pulses 1 cycle after the last transfer; ovf=0.
//  2 mode=01, n=6, ready toggling 1010..: 2,1,3,4,7,11.
//    Data/idx stable on every stalled cycle; no term is lost or duplicated.
//  3 mode=10, n=8, ready=1: 0,0,1,1,2,4,7,13; done pulse.
//  4 WIDTH=16, mode=00, n=30: 25 terms (idx 0..24, last 46368), then done=1, ovf=1.
//    ovf clears on the next start.
//  5 mode=11, seed0=5, seed1=7, n=4: 5,7,12,19.
//    Separately, n=0: done 1 cycle after start, out_valid never rises.
//  6 Mid-run checks:
//    - start during RUN: ignored, sequence unaffected.
//    - rst at idx=3: all outputs back to reset values next cycle, no done pulse.
//    - a fresh start afterwards: restarts from idx 0.

Source files
------------

// File: rtl/seq_gen_stream_if.sv
// Stream interface for the sequence generator: command inputs, the
// valid/ready term stream and the status flags.
interface seq_gen_stream_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic [CNT_W-1:0] n_terms;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_idx;
    logic             busy;
    logic             done;
    logic             ovf;

    // Command/consumer side
    modport master (
        output start, mode, seed0, seed1, n_terms, out_ready,
        input  out_valid, out_data, out_idx, busy, done, ovf
    );

    // Generator side
    modport slave (
        input  start, mode, seed0, seed1, n_terms, out_ready,
        output out_valid, out_data, out_idx, busy, done, ovf
    );
endinterface

// File: rtl/seq_gen_stream.sv
// Integer-recurrence sequence generator (Fibonacci, Lucas, Tribonacci,
// custom two-seed) streaming n_terms terms over valid/ready, stopping
// early with a sticky ovf flag before any term exceeds WIDTH bits.
module seq_gen_stream #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_gen_stream_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // a_q is the presented term; b_q/c_q are the precomputed successors.
    // a_q never needs a too-big tag: it only ever takes b_q when b_q fits.
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic             b_big_q, c_big_q;
    logic             trib_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] idx_q;
    logic             ovf_q;

    logic             xfer;
    logic             last_term;
    logic             accept;
    logic             shift;
    logic             ovf_set;

    // Sums carry two extra bits so three WIDTH-bit operands never wrap
    logic [WIDTH+1:0] sum2, sum3;
    logic             sum2_big, sum3_big;

    assign sum2     = {2'b00, a_q} + {2'b00, b_q};
    assign sum3     = sum2 + {2'b00, c_q};
    assign sum2_big = b_big_q | (|sum2[WIDTH+1:WIDTH]);
    assign sum3_big = b_big_q | c_big_q | (|sum3[WIDTH+1:WIDTH]);

    assign xfer      = (state_q == S_RUN) && bus.out_ready;
    assign last_term = (idx_q == n_q - CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and datapath control; a normal finish takes priority over overflow
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        shift   = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (bus.n_terms == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (last_term) begin
                        state_d = S_DONE;
                    end else if (b_big_q) begin
                        state_d = S_DONE;
                        ovf_set = 1'b1;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Term pipeline, index counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            b_big_q <= 1'b0;
            c_big_q <= 1'b0;
            trib_q  <= 1'b0;
            n_q     <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                idx_q  <= '0;
                n_q    <= bus.n_terms;
                trib_q <= (bus.mode == 2'b10);
                ovf_q  <= 1'b0;
                // With n_terms=0 nothing is emitted, so out_data keeps its old value
                if (bus.n_terms != '0) begin
                    b_big_q <= 1'b0;
                    c_big_q <= 1'b0;
                    c_q     <= '0;
                    case (bus.mode)
                        2'b00: begin a_q <= '0;        b_q <= WIDTH'(1); end
                        2'b01: begin a_q <= WIDTH'(2); b_q <= WIDTH'(1); end
                        2'b10: begin a_q <= '0;        b_q <= '0; c_q <= WIDTH'(1); end
                        default: begin a_q <= bus.seed0; b_q <= bus.seed1; end
                    endcase
                end
            end else if (shift) begin
                idx_q <= idx_q + CNT_W'(1);
                a_q   <= b_q;
                if (trib_q) begin
                    b_q     <= c_q;
                    b_big_q <= c_big_q;
                    c_q     <= sum3[WIDTH-1:0];
                    c_big_q <= sum3_big;
                end else begin
                    b_q     <= sum2[WIDTH-1:0];
                    b_big_q <= sum2_big;
                end
            end
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    assign bus.out_valid = (state_q == S_RUN);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_data  = a_q;
    assign bus.out_idx   = idx_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_gen_stream.sv
// Self-checking bench for seq_gen_stream: directed and random sequences,
// expected terms computed from the recurrence and checked by a monitor.
module tb_seq_gen_stream;
    localparam int     WIDTH = 16;
    localparam int     CNT_W = 8;
    localparam longint MAXV  = (64'd1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_gen_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_gen_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed      = 0;
    int total       = 0;
    int done_count  = 0;
    int done_target = 0;
    int rdy_pat     = 0;  // 0 always ready, 1 toggling, 2 random
    bit rdy_tog     = 1'b0;

    longint exp_data[$];
    int     exp_idx[$];
    bit     exp_ovf[$];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Reference: expand the recurrence in plain integers, stop at the first
    // term that does not fit or at n terms
    task automatic push_expect(input int mode, input longint s0, input longint s1, input int n);
        longint t[$];
        longint nx;
        int k;
        case (mode)
            0: begin t.push_back(0); t.push_back(1); end
            1: begin t.push_back(2); t.push_back(1); end
            2: begin t.push_back(0); t.push_back(0); t.push_back(1); end
            default: begin t.push_back(s0); t.push_back(s1); end
        endcase
        k = 0;
        while (k < n) begin
            if (k >= t.size()) begin
                if (mode == 2) nx = t[k-1] + t[k-2] + t[k-3];
                else           nx = t[k-1] + t[k-2];
                if (nx > MAXV) break;
                t.push_back(nx);
            end
            exp_data.push_back(t[k]);
            exp_idx.push_back(k);
            k++;
        end
        exp_ovf.push_back(k < n);
        $display("start mode=%0d seed0=%0d seed1=%0d n=%0d expect_terms=%0d expect_ovf=%0d",
                 mode, s0, s1, n, k, (k < n));
    endtask

    // Consumer ready pattern, driven just after each rising edge
    always begin
        @(posedge clk);
        #1;
        case (rdy_pat)
            0: bus.out_ready = 1'b1;
            1: begin rdy_tog = ~rdy_tog; bus.out_ready = rdy_tog; end
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares presented terms and done pulses against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_data.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_term: got idx=%0d data=%0d, required no term",
                             bus.out_idx, bus.out_data);
                end else begin
                    check("term_data", bus.out_data, exp_data[0]);
                    check("term_idx", bus.out_idx, exp_idx[0]);
                    check("busy_in_run", bus.busy, 1);
                    if (bus.out_ready) begin
                        $display("xfer idx=%0d data=%0d", bus.out_idx, bus.out_data);
                        void'(exp_data.pop_front());
                        void'(exp_idx.pop_front());
                    end
                end
            end
            if (bus.done) begin
                if (exp_ovf.size() == 0) begin
                    total++;
                    $display("FAIL spurious_done: got done=1, required done=0");
                end else begin
                    check("done_ovf", bus.ovf, exp_ovf[0]);
                    check("terms_left_at_done", exp_data.size(), 0);
                    check("valid_low_in_done", bus.out_valid, 0);
                    $display("done ovf=%0d", bus.ovf);
                    void'(exp_ovf.pop_front());
                    done_count++;
                end
            end
        end
    end

    task automatic issue_seq(input int mode, input longint s0, input longint s1,
                             input int n, input int pat);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        while (bus.busy && guard < 300) begin
            @(posedge clk); #2;
            guard++;
        end
        if (bus.busy) check("idle_timeout", bus.busy, 0);
        rdy_pat     = pat;
        bus.mode    = 2'(mode);
        bus.seed0   = WIDTH'(s0);
        bus.seed1   = WIDTH'(s1);
        bus.n_terms = CNT_W'(n);
        bus.start   = 1'b1;
        done_target = done_count + 1;
        push_expect(mode, s0, s1, n);
        @(posedge clk); #2;
        bus.start = 1'b0;
        check("latency_valid", bus.out_valid, (n != 0));
        check("busy_after_start", bus.busy, 1);
        check("idx_after_start", bus.out_idx, 0);
        check("ovf_cleared", bus.ovf, 0);
        check("done_after_start", bus.done, (n == 0));
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done_count < done_target && guard < 3000) begin
            @(posedge clk); #2;
            guard++;
        end
        if (done_count < done_target) check("done_timeout", done_count, done_target);
    endtask

    task automatic run_seq(input int mode, input longint s0, input longint s1,
                           input int n, input int pat);
        issue_seq(mode, s0, s1, n, pat);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_idx"}, bus.out_idx, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_ovf"}, bus.ovf, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bus.start   = 1'b0;
        bus.mode    = 2'b00;
        bus.seed0   = '0;
        bus.seed1   = '0;
        bus.n_terms = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst = 1'b0;

        run_seq(0, 0, 0, 10, 0);   // Fibonacci back-to-back
        run_seq(1, 0, 0, 6, 1);    // Lucas with stalls
        run_seq(2, 0, 0, 8, 0);    // Tribonacci
        run_seq(0, 0, 0, 30, 2);   // overflow stop after 25 terms
        run_seq(0, 0, 0, 25, 0);   // last term coincides with overflow: normal finish
        run_seq(3, 5, 7, 4, 2);    // custom seeds
        run_seq(0, 0, 0, 0, 0);    // n=0: done only
        run_seq(3, 60000, 9000, 5, 0); // first sum overflows

        // start during RUN is ignored
        issue_seq(0, 0, 0, 20, 2);
        repeat (2) @(posedge clk);
        #2;
        bus.mode = 2'b01; bus.n_terms = 8'd5; bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        check("busy_ignored_start", bus.busy, 1);
        wait_done();

        // reset in the middle of a sequence
        issue_seq(0, 0, 0, 10, 0);
        g = 0;
        while (!(bus.out_valid && bus.out_idx == 3) && g < 50) begin
            @(posedge clk); #2;
            g++;
        end
        check("reached_idx3", bus.out_idx, 3);
        rst = 1'b1;
        @(posedge clk); #2;
        check_reset_outputs("midrst");
        exp_data.delete();
        exp_idx.delete();
        exp_ovf.delete();
        rst = 1'b0;
        done_target = done_count;
        repeat (5) @(posedge clk);
        run_seq(1, 0, 0, 6, 1);    // fresh start after reset

        // random sequences
        for (int i = 0; i < 25; i++) begin
            int     md;
            longint s0, s1;
            md = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                s0 = longint'($urandom_range(0, 65535));
                s1 = longint'($urandom_range(0, 65535));
            end else begin
                s0 = longint'($urandom_range(0, 50));
                s1 = longint'($urandom_range(0, 50));
            end
            run_seq(md, s0, s1, int'($urandom_range(0, 40)), int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
